// File: rtl/sd_dev_pkg.sv
// Shared types and constants for the SD device command-line engine.
// State encoding, frame geometry and the CRC7 step used on the CMD line.
package sd_dev_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_RX_CHECK,
        ST_TX_GAP,
        ST_TX,
        ST_TX_END
    } cmd_state_t;

    localparam int SHORT_LEN = 48;
    localparam int LONG_LEN  = 136;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    // Bit positions inside a 48-bit frame (bit 47 is the start bit).
    localparam int TXB_POS = 46;
    localparam int IDX_LSB = 40;
    localparam int ARG_LSB = 8;
    localparam int CRC_LSB = 1;

    function automatic logic [6:0] crc7_step(input logic [6:0] c,
                                             input logic d);
        logic fb;
        fb = d ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), zero seed, one bit per enable.
// Shared by receive and transmit since the CMD line is half-duplex.
module sd_crc7
    import sd_dev_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       din,
    output logic [6:0] crc
);

    // Clear has priority so a new frame always starts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            crc <= 7'h00;
        else if (clr)
            crc <= 7'h00;
        else if (en)
            crc <= crc7_step(crc, din);
    end

endmodule

// File: rtl/sd_dev_cmd_layer.sv
// SD device CMD-line engine: 48-bit command receive, 48/136-bit response send.
// Define SD_CMD_RX_CRC_CHECK_EN to reject received frames on CRC7 mismatch.
module sd_dev_cmd_layer
    import sd_dev_pkg::*;
#(
    parameter int NCR = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_bit_stb,
    input  logic         i_sd_cmd_in,
    output logic         o_sd_cmd_dir,
    output logic         o_sd_cmd_out,
    output logic         o_cmd_stb,
    output logic [5:0]   o_cmd_index,
    output logic [31:0]  o_cmd_arg,
    output logic         o_cmd_crc_err,
    input  logic         i_rsp_stb,
    input  logic         i_rsp_long,
    input  logic [5:0]   i_rsp_index,
    input  logic [127:0] i_rsp_data,
    output logic         o_rsp_busy,
    output logic         o_rsp_done
);

    cmd_state_t   state_q, state_n;
    logic [7:0]   cnt_q, cnt_n;
    logic [46:0]  rx_sr_q, rx_sr_n;
    logic [135:0] frame_q, frame_n;
    logic         long_q, long_n;
    logic         dir_q, dir_n;
    logic         out_q, out_n;
    logic         stb_q, stb_n;
    logic         err_q, err_n;
    logic [5:0]   idx_q, idx_n;
    logic [31:0]  arg_q, arg_n;
    logic         busy_q, busy_n;
    logic         done_q, done_n;

    logic [6:0]   crc;
    logic         crc_en, crc_clr, crc_din;
    logic         crc_ok;
    logic [7:0]   pos;
    logic [7:0]   top;
    logic [2:0]   cidx;

    logic         unused_rsp_lsb;
    assign unused_rsp_lsb = i_rsp_data[0];

    sd_crc7 u_crc (
        .clk (clk),
        .rst (rst),
        .en  (crc_en),
        .clr (crc_clr),
        .din (crc_din),
        .crc (crc)
    );

`ifdef SD_CMD_RX_CRC_CHECK_EN
    assign crc_ok = (crc == rx_sr_q[CRC_LSB +: 7]);
`else
    assign crc_ok = 1'b1;
`endif

    // Next-state, datapath and output decode; everything is registered below.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        rx_sr_n = rx_sr_q;
        frame_n = frame_q;
        long_n  = long_q;
        dir_n   = dir_q;
        out_n   = out_q;
        stb_n   = 1'b0;
        err_n   = 1'b0;
        idx_n   = idx_q;
        arg_n   = arg_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        crc_en  = 1'b0;
        crc_clr = 1'b0;
        crc_din = 1'b0;
        pos     = cnt_q - 8'd1;
        top     = long_q ? 8'(LONG_LEN - 1) : 8'(SHORT_LEN - 1);
        cidx    = pos[2:0] - 3'd1;

        unique case (state_q)
            ST_IDLE: begin
                crc_clr = 1'b1;
                if (i_bit_stb) begin
                    if (!i_sd_cmd_in) begin
                        state_n = ST_RX;
                        cnt_n   = 8'(SHORT_LEN - 1);
                    end else if (i_rsp_stb) begin
                        state_n = ST_TX_GAP;
                        cnt_n   = 8'(NCR - 1);
                        busy_n  = 1'b1;
                        dir_n   = 1'b1;
                        out_n   = 1'b1;
                        long_n  = i_rsp_long;
                        if (i_rsp_long)
                            frame_n = {2'b00, 6'h3f, i_rsp_data[127:1], 1'b1};
                        else
                            frame_n = {88'd0, 2'b00, i_rsp_index,
                                       i_rsp_data[31:0], 8'h01};
                    end
                end
            end
            ST_RX: begin
                if (i_bit_stb) begin
                    rx_sr_n = {rx_sr_q[45:0], i_sd_cmd_in};
                    cnt_n   = pos;
                    crc_en  = (cnt_q > 8'(ARG_LSB));
                    crc_din = i_sd_cmd_in;
                    if (cnt_q == 8'd1)
                        state_n = ST_RX_CHECK;
                end
            end
            ST_RX_CHECK: begin
                state_n = ST_IDLE;
                if (rx_sr_q[TXB_POS] && rx_sr_q[0] && crc_ok) begin
                    stb_n = 1'b1;
                    idx_n = rx_sr_q[IDX_LSB +: 6];
                    arg_n = rx_sr_q[ARG_LSB +: 32];
                end else begin
                    err_n = 1'b1;
                end
            end
            ST_TX_GAP: begin
                if (i_bit_stb) begin
                    if (cnt_q == 8'd0) begin
                        state_n = ST_TX;
                        cnt_n   = top;
                        out_n   = frame_q[top];
                        crc_en  = !long_q;
                        crc_din = frame_q[top];
                    end else begin
                        cnt_n = pos;
                    end
                end
            end
            ST_TX: begin
                if (i_bit_stb) begin
                    if (cnt_q == 8'd0) begin
                        state_n = ST_TX_END;
                        out_n   = 1'b1;
                    end else begin
                        cnt_n   = pos;
                        crc_en  = !long_q && (pos >= 8'(ARG_LSB));
                        crc_din = frame_q[pos];
                        if (!long_q && pos >= 8'(CRC_LSB) && pos < 8'(ARG_LSB))
                            out_n = crc[cidx];
                        else
                            out_n = frame_q[pos];
                    end
                end
            end
            ST_TX_END: begin
                if (i_bit_stb) begin
                    state_n = ST_IDLE;
                    dir_n   = 1'b0;
                    out_n   = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and output registers; reset releases the line immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            rx_sr_q <= '0;
            frame_q <= '0;
            long_q  <= 1'b0;
            dir_q   <= 1'b0;
            out_q   <= 1'b1;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= 6'd0;
            arg_q   <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            rx_sr_q <= rx_sr_n;
            frame_q <= frame_n;
            long_q  <= long_n;
            dir_q   <= dir_n;
            out_q   <= out_n;
            stb_q   <= stb_n;
            err_q   <= err_n;
            idx_q   <= idx_n;
            arg_q   <= arg_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign o_sd_cmd_dir  = dir_q;
    assign o_sd_cmd_out  = out_q;
    assign o_cmd_stb     = stb_q;
    assign o_cmd_index   = idx_q;
    assign o_cmd_arg     = arg_q;
    assign o_cmd_crc_err = err_q;
    assign o_rsp_busy    = busy_q;
    assign o_rsp_done    = done_q;

endmodule

// File: tb/tb_sd_dev_cmd_layer.sv
// Self-checking bench for sd_dev_cmd_layer.
// Frames and CRCs come from a polynomial-division model in the bench.
module tb_sd_dev_cmd_layer;

    localparam int NCR = 2;
`ifdef SD_CMD_RX_CRC_CHECK_EN
    localparam bit CRC_CHK = 1'b1;
`else
    localparam bit CRC_CHK = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         i_bit_stb;
    logic         i_sd_cmd_in;
    logic         o_sd_cmd_dir;
    logic         o_sd_cmd_out;
    logic         o_cmd_stb;
    logic [5:0]   o_cmd_index;
    logic [31:0]  o_cmd_arg;
    logic         o_cmd_crc_err;
    logic         i_rsp_stb;
    logic         i_rsp_long;
    logic [5:0]   i_rsp_index;
    logic [127:0] i_rsp_data;
    logic         o_rsp_busy;
    logic         o_rsp_done;

    int checks = 0;
    int passed = 0;
    int stb_seen = 0;
    int err_seen = 0;
    int done_seen = 0;

    logic s_dir, s_out, s_done, s_busy;
    logic [5:0]  m_idx;
    logic [31:0] m_arg;

    sd_dev_cmd_layer #(.NCR(NCR)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_bit_stb     (i_bit_stb),
        .i_sd_cmd_in   (i_sd_cmd_in),
        .o_sd_cmd_dir  (o_sd_cmd_dir),
        .o_sd_cmd_out  (o_sd_cmd_out),
        .o_cmd_stb     (o_cmd_stb),
        .o_cmd_index   (o_cmd_index),
        .o_cmd_arg     (o_cmd_arg),
        .o_cmd_crc_err (o_cmd_crc_err),
        .i_rsp_stb     (i_rsp_stb),
        .i_rsp_long    (i_rsp_long),
        .i_rsp_index   (i_rsp_index),
        .i_rsp_data    (i_rsp_data),
        .o_rsp_busy    (o_rsp_busy),
        .o_rsp_done    (o_rsp_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled before the edge updates the registers.
    always @(posedge clk) begin
        if (o_cmd_stb === 1'b1) stb_seen++;
        if (o_cmd_crc_err === 1'b1) err_seen++;
        if (o_rsp_done === 1'b1) done_seen++;
    end

    initial begin
        #5000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    // CRC7 as remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_div(input logic [39:0] m);
        logic [46:0] v;
        v = {m, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (v[i]) v = v ^ (47'h89 << (i - 7));
        return v[6:0];
    endfunction

    function automatic logic [47:0] cmd_frame(input logic [5:0] idx,
                                              input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b01, idx, arg};
        return {h, crc7_div(h), 1'b1};
    endfunction

    function automatic logic [135:0] rsp_frame(input logic lng,
                                               input logic [5:0] idx,
                                               input logic [127:0] d);
        logic [39:0] h;
        h = {2'b00, idx, d[31:0]};
        if (lng) return {2'b00, 6'h3f, d[127:1], 1'b1};
        return {88'd0, h, crc7_div(h), 1'b1};
    endfunction

    // Line as seen per strobe: NCR idle-high gap, frame, trailing 1.
    function automatic logic [255:0] exp_stream(input logic lng,
                                                input logic [135:0] f);
        logic [255:0] e;
        int len;
        len = lng ? 136 : 48;
        e = '0;
        for (int i = 0; i < NCR; i++) e = {e[254:0], 1'b1};
        for (int i = len - 1; i >= 0; i--) e = {e[254:0], f[i]};
        e = {e[254:0], 1'b1};
        return e;
    endfunction

    task automatic bit_time(input logic b);
        @(negedge clk);
        i_sd_cmd_in = b;
        i_bit_stb = 1'b1;
        @(negedge clk);
        i_bit_stb = 1'b0;
        s_dir = o_sd_cmd_dir;
        s_out = o_sd_cmd_out;
        s_done = o_rsp_done;
        s_busy = o_rsp_busy;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) bit_time(f[i]);
    endtask

    task automatic run_rsp(input logic lng, input logic [5:0] idx,
                           input logic [127:0] d,
                           output logic [255:0] strm,
                           output int bad_hold, output int done_at);
        int n;
        n = NCR + (lng ? 136 : 48) + 2;
        strm = '0;
        bad_hold = 0;
        done_at = -1;
        i_rsp_long = lng;
        i_rsp_index = idx;
        i_rsp_data = d;
        i_rsp_stb = 1'b1;
        for (int k = 0; k < n; k++) begin
            bit_time(1'b1);
            if (k == 0) begin
                i_rsp_stb = 1'b0;
                i_rsp_data = ~d;
                i_rsp_index = ~idx;
                i_rsp_long = ~lng;
            end
            strm = {strm[254:0], s_out};
            if (k < n - 1) begin
                if (!(s_dir === 1'b1 && s_busy === 1'b1)) bad_hold++;
            end else begin
                if (!(s_dir === 1'b0 && s_busy === 1'b0)) bad_hold++;
            end
            if (s_done === 1'b1) begin
                if (done_at < 0) done_at = k;
                else bad_hold++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_sd_cmd_dir, o_sd_cmd_out, o_cmd_stb, o_cmd_crc_err,
             o_rsp_busy, o_rsp_done} !== 6'b010000)
            $display("FAIL reset_ctrl got %b want 010000",
                     {o_sd_cmd_dir, o_sd_cmd_out, o_cmd_stb,
                      o_cmd_crc_err, o_rsp_busy, o_rsp_done});
        else passed++;
        checks++;
        if ({o_cmd_index, o_cmd_arg} !== 38'd0)
            $display("FAIL reset_fields got %h want 0",
                     {o_cmd_index, o_cmd_arg});
        else passed++;
        rst = 1'b1;
        m_idx = 6'd0;
        m_arg = 32'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cmd_directed;
        logic [47:0] fr [3];
        logic        ok [3];
        logic [5:0]  ei [3];
        logic [31:0] ea [3];
        fr[0] = 48'h48000001AA87; ok[0] = 1'b1;
        ei[0] = 6'd8; ea[0] = 32'h000001AA;
        fr[1] = 48'h400000000095; ok[1] = 1'b1;
        ei[1] = 6'd0; ea[1] = 32'h0;
        fr[2] = 48'h48000001AA89; ok[2] = !CRC_CHK;
        ei[2] = CRC_CHK ? 6'd0 : 6'd8;
        ea[2] = CRC_CHK ? 32'h0 : 32'h000001AA;
        for (int t = 0; t < 3; t++) begin
            send_frame(fr[t]);
            checks++;
            if (o_cmd_stb !== ok[t])
                $display("FAIL dir_stb[%0d] got %b want %b", t, o_cmd_stb, ok[t]);
            else passed++;
            checks++;
            if (o_cmd_crc_err !== !ok[t])
                $display("FAIL dir_err[%0d] got %b want %b",
                         t, o_cmd_crc_err, !ok[t]);
            else passed++;
            checks++;
            if (o_cmd_index !== ei[t])
                $display("FAIL dir_idx[%0d] got %0d want %0d", t, o_cmd_index, ei[t]);
            else passed++;
            checks++;
            if (o_cmd_arg !== ea[t])
                $display("FAIL dir_arg[%0d] got %h want %h", t, o_cmd_arg, ea[t]);
            else passed++;
            @(negedge clk);
            checks++;
            if ({o_cmd_stb, o_cmd_crc_err} !== 2'b00)
                $display("FAIL dir_pulse_len[%0d] got %b want 00",
                         t, {o_cmd_stb, o_cmd_crc_err});
            else passed++;
        end
        m_idx = ei[2];
        m_arg = ea[2];
    endtask

    task automatic test_cmd_random;
        logic [47:0] f;
        logic [5:0]  idx;
        logic [31:0] arg;
        int kind;
        logic ok;
        for (int n = 0; n < 24; n++) begin
            idx = 6'($urandom);
            arg = $urandom;
            kind = $urandom_range(0, 3);
            f = cmd_frame(idx, arg);
            if (kind == 1) f[7:1] = f[7:1] ^ 7'($urandom_range(1, 127));
            if (kind == 2) f[46] = 1'b0;
            if (kind == 3) f[0] = 1'b0;
            ok = (kind == 0) || (kind == 1 && !CRC_CHK);
            if (ok) begin
                m_idx = idx;
                m_arg = arg;
            end
            send_frame(f);
            checks++;
            if ({o_cmd_stb, o_cmd_crc_err} !== {ok, !ok})
                $display("FAIL rnd_pulse[%0d] kind %0d got %b want %b",
                         n, kind, {o_cmd_stb, o_cmd_crc_err}, {ok, !ok});
            else passed++;
            checks++;
            if ({o_cmd_index, o_cmd_arg} !== {m_idx, m_arg})
                $display("FAIL rnd_fields[%0d] got %h want %h",
                         n, {o_cmd_index, o_cmd_arg}, {m_idx, m_arg});
            else passed++;
        end
    endtask

    task automatic test_short_rsp;
        logic [255:0] strm;
        logic [255:0] e;
        int bad, dat, d0;
        d0 = done_seen;
        e = exp_stream(1'b0, {88'd0, 48'h08000001AA13});
        run_rsp(1'b0, 6'd8, {96'd0, 32'h000001AA}, strm, bad, dat);
        repeat (3) @(negedge clk);
        checks++;
        if ((strm >> 1) !== e)
            $display("FAIL short_line got %h want %h", strm >> 1, e);
        else passed++;
        checks++;
        if (bad !== 0 || dat !== NCR + 48 + 1)
            $display("FAIL short_hold bad %0d done_at %0d want 0 %0d",
                     bad, dat, NCR + 49);
        else passed++;
        checks++;
        if (done_seen - d0 !== 1)
            $display("FAIL short_done_cnt got %0d want 1", done_seen - d0);
        else passed++;
    endtask

    task automatic test_long_rsp;
        logic [255:0] strm;
        logic [255:0] e;
        logic [127:0] d;
        int bad, dat;
        d = {16{8'hA5}};
        e = exp_stream(1'b1, {2'b00, 6'h3f, d[127:1], 1'b1});
        run_rsp(1'b1, 6'd2, d, strm, bad, dat);
        checks++;
        if ((strm >> 1) !== e)
            $display("FAIL long_line got %h want %h", strm >> 1, e);
        else passed++;
        checks++;
        if (bad !== 0 || dat !== NCR + 136 + 1)
            $display("FAIL long_busy bad %0d done_at %0d want 0 %0d",
                     bad, dat, NCR + 137);
        else passed++;
    endtask

    task automatic test_rsp_random;
        logic [255:0] strm;
        logic [127:0] d;
        logic [5:0] idx;
        logic lng;
        int bad, dat;
        for (int n = 0; n < 6; n++) begin
            lng = 1'($urandom);
            idx = 6'($urandom);
            d = {$urandom, $urandom, $urandom, $urandom};
            run_rsp(lng, idx, d, strm, bad, dat);
            checks++;
            if ((strm >> 1) !== exp_stream(lng, rsp_frame(lng, idx, d)))
                $display("FAIL rnd_rsp[%0d] long %b got %h want %h", n, lng,
                         strm >> 1, exp_stream(lng, rsp_frame(lng, idx, d)));
            else passed++;
            checks++;
            if (bad !== 0 || dat !== NCR + (lng ? 136 : 48) + 1)
                $display("FAIL rnd_rsp_hold[%0d] bad %0d done_at %0d", n, bad, dat);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        logic [255:0] strm;
        logic [127:0] d;
        int bad, dat, s0;
        s0 = stb_seen;
        d = {96'd0, $urandom};
        send_frame(cmd_frame(6'd55, 32'h12345678));
        run_rsp(1'b0, 6'd55, d, strm, bad, dat);
        m_idx = 6'd55;
        m_arg = 32'h12345678;
        checks++;
        if (stb_seen - s0 !== 1 || o_cmd_index !== 6'd55)
            $display("FAIL b2b_cmd got %0d idx %0d want 1 55",
                     stb_seen - s0, o_cmd_index);
        else passed++;
        checks++;
        if ((strm >> 1) !== exp_stream(1'b0, rsp_frame(1'b0, 6'd55, d)) || bad !== 0)
            $display("FAIL b2b_rsp got %h bad %0d", strm >> 1, bad);
        else passed++;
    endtask

    task automatic test_rx_priority;
        logic [47:0] f;
        int d0;
        d0 = done_seen;
        f = cmd_frame(6'd9, 32'hCAFE0001);
        i_rsp_long = 1'b0;
        i_rsp_stb = 1'b1;
        bit_time(f[47]);
        i_rsp_stb = 1'b0;
        checks++;
        if (s_busy !== 1'b0)
            $display("FAIL prio_busy got %b want 0", s_busy);
        else passed++;
        for (int i = 46; i >= 0; i--) bit_time(f[i]);
        checks++;
        if (o_cmd_stb !== 1'b1 || o_cmd_arg !== 32'hCAFE0001)
            $display("FAIL prio_cmd got %b %h want 1 cafe0001", o_cmd_stb, o_cmd_arg);
        else passed++;
        m_idx = 6'd9;
        m_arg = 32'hCAFE0001;
        repeat (4) bit_time(1'b1);
        checks++;
        if (s_busy !== 1'b0 || s_dir !== 1'b0 || done_seen !== d0)
            $display("FAIL prio_dropped got busy %b dir %b done %0d want 0 0 0",
                     s_busy, s_dir, done_seen - d0);
        else passed++;
    endtask

    task automatic test_reset_abort;
        logic [47:0] f;
        int s0, e0;
        send_frame(48'h48000001AA87);
        bit_time(1'b1);
        s0 = stb_seen;
        e0 = err_seen;
        f = cmd_frame(6'd17, 32'hDEADBEEF);
        for (int i = 47; i >= 27; i--) bit_time(f[i]);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_sd_cmd_dir, o_sd_cmd_out, o_rsp_busy} !== 3'b010 ||
            {o_cmd_index, o_cmd_arg} !== 38'd0)
            $display("FAIL abort_state got %b %h want 010 0",
                     {o_sd_cmd_dir, o_sd_cmd_out, o_rsp_busy},
                     {o_cmd_index, o_cmd_arg});
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bit_time(1'b1);
        bit_time(1'b1);
        checks++;
        if (stb_seen !== s0 || err_seen !== e0)
            $display("FAIL abort_pulses got %0d %0d want 0 0",
                     stb_seen - s0, err_seen - e0);
        else passed++;
        send_frame(48'h400000000095);
        checks++;
        if (o_cmd_stb !== 1'b1 || o_cmd_crc_err !== 1'b0 || o_cmd_index !== 6'd0)
            $display("FAIL abort_cmd0 got %b %b %0d want 1 0 0",
                     o_cmd_stb, o_cmd_crc_err, o_cmd_index);
        else passed++;
    endtask

    initial begin
        rst = 1'b0;
        i_bit_stb = 1'b0;
        i_sd_cmd_in = 1'b1;
        i_rsp_stb = 1'b0;
        i_rsp_long = 1'b0;
        i_rsp_index = 6'd0;
        i_rsp_data = '0;
        test_reset();
        test_cmd_directed();
        test_cmd_random();
        test_short_rsp();
        test_long_rsp();
        test_rsp_random();
        test_back_to_back();
        test_rx_priority();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sd_dev_cmd_layer.md
# sd_dev_cmd_layer

Serial command-line engine for the SD device stack. It sits directly above the SD device platform (PHY) stage and connects to its command-direction, command-out and command-in signals. It deserialises 48-bit host command frames, checks their CRC7 and presents index and argument to the protocol layer. It also serialises 48-bit (short) or 136-bit (long) responses back onto the line.

## Interface
Parameters:
- NCR, default 2: response gap in bit times from command end bit to response start bit; legal range 2..64.

Ports:
- clk  in  1  system clock; the platform's x2 clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- i_bit_stb  in  1  one-cycle strobe per SD bit time, aligned to the SD clock rising edge. All line activity advances only on this strobe.
- i_sd_cmd_in  in  1  sampled command line, from the platform.
- o_sd_cmd_dir  out  1  1 = this block drives the line.
- o_sd_cmd_out  out  1  driven command bit.
- o_cmd_stb  out  1  one-cycle pulse when a valid command is received.
- o_cmd_index  out  6  received command index.
- o_cmd_arg  out  32  received argument.
- o_cmd_crc_err  out  1  one-cycle pulse when a frame is rejected.
- i_rsp_stb  in  1  request to send a response. Sampled only in IDLE.
- i_rsp_long  in  1  1 = 136-bit response, 0 = 48-bit response.
- i_rsp_index  in  6  response index (short responses only).
- i_rsp_data  in  128  short: [31:0] is the argument; long: [127:1] is sent verbatim, including the caller-supplied inner CRC.
- o_rsp_busy  out  1  high from acceptance until the line is released.
- o_rsp_done  out  1  one-cycle pulse on line release.

## Operation
- States: IDLE, RX, RX_CHECK, TX_GAP, TX, TX_END.
- IDLE: line released. Advance only on i_bit_stb.
  - A strobe with i_sd_cmd_in = 0 goes to RX; the bit counter is loaded with 47.
  - Otherwise, i_rsp_stb goes to TX_GAP; the response fields are latched and o_rsp_busy is set.
  - If both occur on the same cycle, RX wins and i_rsp_stb is dropped.
- RX: shift 47 more bits MSB-first, one per strobe. CRC7 (x^7+x^3+1, zero seed) runs over frame bits 47..8. After the end bit, go to RX_CHECK.
- RX_CHECK: one clk cycle, no strobe needed.
  - Accept when transmission bit = 1, end bit = 1 and CRC matches: pulse o_cmd_stb and update o_cmd_index/o_cmd_arg.
  - Otherwise pulse o_cmd_crc_err and leave index/arg unchanged.
  - Then go to IDLE.
- TX_GAP: dir = 1, out = 1 for NCR strobes, then go to TX.
- TX, short frame (48 bits): 0, 0, index[5:0], arg[31:0], CRC7 computed over the first 40 bits, 1.
- TX, long frame (136 bits): 0, 0, 6'b111111, data[127:1], 1.
- TX_END: after the end bit, drive out = 1 for one more strobe. Then dir = 0, pulse o_rsp_done, clear o_rsp_busy, go to IDLE.
- i_sd_cmd_in is ignored outside IDLE and RX. i_rsp_stb is ignored outside IDLE.
- Reset mid-frame aborts immediately: line released, no strobes, no partial update.

## Timing
- Reset values: o_sd_cmd_dir 0, o_sd_cmd_out 1, o_cmd_stb 0, o_cmd_index 0, o_cmd_arg 0, o_cmd_crc_err 0, o_rsp_busy 0, o_rsp_done 0.
- All outputs are registered.
- o_sd_cmd_out and o_sd_cmd_dir change in the clk cycle after the i_bit_stb that advances them.
- o_cmd_stb / o_cmd_crc_err assert 2 clk cycles after the strobe that samples the end bit.
- Response start bit appears NCR strobes after acceptance. With NCR = 2, the earliest response start bit is 3 bit times after the command end bit, counting the RX_CHECK-to-IDLE acceptance strobe.
- Bit counter is 8 bits wide, counts down, and leaves the state at 0. No wrap-around is possible.

## Configuration
- SD_CMD_RX_CRC_CHECK_EN defined: RX CRC mismatch rejects the frame, as described in Operation.
- SD_CMD_RX_CRC_CHECK_EN undefined: the received CRC field is ignored. Only the transmission and end bits are checked. The TX CRC generator is always present.

## Structure
- Package sd_dev_pkg holds:
  - the state enum;
  - frame lengths: 48 and 136;
  - CRC7 polynomial 7'h09;
  - field offsets.
- Sub-module sd_crc7: serial CRC7 with enable and clear. One instance is shared by RX and TX, which is possible because the line is half-duplex.

## Test plan
- CMD0 frame 48'h400000000095 → o_cmd_stb, index 0, arg 32'h0, no error.
- CMD8 frame 48'h48000001AA87 → o_cmd_stb, index 8, arg 32'h000001AA.
- CMD8 frame with CRC byte 0x89 → o_cmd_crc_err pulse, index/arg unchanged. With the macro undefined → o_cmd_stb instead.
- Short response, index 8, data[31:0] = 32'h000001AA, NCR = 2 → line shows 1,1 then 48'h08000001AA13, then 1, then released; o_rsp_done pulses once.
- Long response with data = 128'hA5 repeated → 136 bits: 0,0,111111, data[127:1], 1. o_rsp_busy is high throughout.
- Reset asserted at RX bit 20, then a valid CMD0 → no strobe from the aborted frame; CMD0 is accepted normally.
